// File: rtl/red_seq_unit.sv
// red_seq_unit: multi-cycle nibble reduction (RED) for the execute stage.
// Sums the eight sign-extended nibbles of A and B through one shared 9-bit
// accumulator, LANES_PER_CYCLE lane pairs per step, under start/stall/flush.
module red_seq_unit #(
    parameter int unsigned LANES_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [15:0] result
);

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ACC_W     = 9;
    localparam int unsigned NIB_W     = 4;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned NUM_STEPS = (LANES_PER_CYCLE == 0) ? 1 : 4 / LANES_PER_CYCLE;

    // Only 1, 2 or 4 lane pairs per step divide the four lanes evenly.
    if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 2 || LANES_PER_CYCLE == 4)) begin : g_bad_lanes
        $error("red_seq_unit: LANES_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   acc;
    logic [DATA_W-1:0]  opa;
    logic [DATA_W-1:0]  opb;

    logic [ACC_W-1:0]   step_sum;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   lane;
    logic [NIB_W-1:0]   nib_a;
    logic [NIB_W-1:0]   nib_b;
    logic               last_step;

    // Sum of the sign-extended nibbles selected by the current step.
    always_comb begin
        step_sum = '0;
        lane     = '0;
        nib_a    = '0;
        nib_b    = '0;
        for (int unsigned j = 0; j < LANES_PER_CYCLE; j++) begin
            lane     = CNT_W'(32'(cnt) * LANES_PER_CYCLE + j);
            nib_a    = opa[{lane, 2'b00} +: NIB_W];
            nib_b    = opb[{lane, 2'b00} +: NIB_W];
            step_sum = step_sum + {{(ACC_W-NIB_W){nib_a[NIB_W-1]}}, nib_a}
                                + {{(ACC_W-NIB_W){nib_b[NIB_W-1]}}, nib_b};
        end
        acc_next  = acc + step_sum;
        last_step = (cnt == CNT_W'(NUM_STEPS - 1));
    end

    // Sequencer: accept, accumulate, signal completion; flush beats stall beats start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (!stall) begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= A;
                        opb   <= B;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= {{(DATA_W-ACC_W){acc_next[ACC_W-1]}}, acc_next};
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= A;
                        opb   <= B;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_ACCUM;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_red_seq_unit.sv
// Bench for red_seq_unit: three instances (1, 2, 4 lanes per cycle) on shared
// stimulus, checked every cycle against a protocol-level reference model.
module tb_red_seq_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        stall;
    logic        flush;
    logic        busy_v   [3];
    logic        done_v   [3];
    logic [15:0] result_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        red_seq_unit #(.LANES_PER_CYCLE(1 << g)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start),
            .A      (A),
            .B      (B),
            .stall  (stall),
            .flush  (flush),
            .busy   (busy_v[g]),
            .done   (done_v[g]),
            .result (result_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int          ns     [3] = '{4, 2, 1};
    int          m_left [3];
    logic        m_done [3];
    logic [15:0] m_pend [3];
    logic [15:0] m_res  [3];
    int          lat    [3];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] b);
        int s = 0;
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            n = a[i*4 +: 4];
            s += n[3] ? int'(n) - 16 : int'(n);
            n = b[i*4 +: 4];
            s += n[3] ? int'(n) - 16 : int'(n);
        end
        return 16'(s);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0;
            m_done[k] = 1'b0;
            m_pend[k] = '0;
            m_res[k]  = '0;
        end
    endtask

    // Protocol model: remaining accumulate edges, done flag, pending/visible result.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_left[k] = 0;
                m_done[k] = 1'b0;
                m_res[k]  = '0;
            end else if (flush) begin
                m_left[k] = 0;
                m_done[k] = 1'b0;
            end else if (stall) begin
                // everything holds
            end else if (m_left[k] > 0) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_done[k] = 1'b1;
                    m_res[k]  = m_pend[k];
                end
            end else begin
                m_done[k] = 1'b0;
                if (start) begin
                    m_left[k] = ns[k];
                    m_pend[k] = ref_red(A, B);
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy[%0d]", k), 16'(busy_v[k]), 16'(m_left[k] > 0));
            chk($sformatf("done[%0d]", k), 16'(done_v[k]), 16'(m_done[k]));
            chk($sformatf("result[%0d]", k), result_v[k], m_res[k]);
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Accept one op, optionally stall 3 edges from edge stall_at, record first done per instance.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int stall_at);
        start = 1'b1;
        A = a;
        B = b;
        cyc();
        start = 1'b0;
        lat = '{-1, -1, -1};
        for (int n = 1; n <= 30; n++) begin
            if (n == stall_at) begin
                stall = 1'b1;
                A = 16'h8888;
            end
            if (stall_at > 0 && n == stall_at + 3) stall = 1'b0;
            cyc();
            for (int k = 0; k < 3; k++)
                if (done_v[k] && lat[k] < 0) lat[k] = n;
        end
        stall = 1'b0;
    endtask

    initial begin
        vec_t vecs [4];
        int   first;
        int   second;
        bit   seen;

        vecs[0] = '{16'h1234, 16'h0000, 16'h000A};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFF8};
        vecs[2] = '{16'h7777, 16'h7777, 16'h0038};
        vecs[3] = '{16'h8888, 16'h8888, 16'hFFC0};

        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        A     = '0;
        B     = '0;
        model_reset();
        #11;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy[%0d]", k), 16'(busy_v[k]), 16'h0);
            chk($sformatf("rst_done[%0d]", k), 16'(done_v[k]), 16'h0);
            chk($sformatf("rst_result[%0d]", k), result_v[k], 16'h0000);
        end
        #1 rst_n = 1'b1;
        cyc();

        // Table vectors: result and latency per lane width.
        for (int v = 0; v < 4; v++) begin
            run_op(vecs[v].a, vecs[v].b, -1);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("vec%0d_lat[%0d]", v, k), 16'(lat[k]), 16'(ns[k]));
                chk($sformatf("vec%0d_result[%0d]", v, k), result_v[k], vecs[v].exp);
            end
        end

        // Stall held 3 edges mid-accumulate, A changed while busy.
        run_op(16'h7777, 16'h7777, 2);
        chk("stall_lat[0]", 16'(lat[0]), 16'd7);
        chk("stall_lat[1]", 16'(lat[1]), 16'd5);
        for (int k = 0; k < 3; k++)
            chk($sformatf("stall_result[%0d]", k), result_v[k], 16'h0038);

        // Flush mid-operation after a 000A result.
        run_op(16'h1234, 16'h0000, -1);
        start = 1'b1;
        A = 16'hFFFF;
        B = 16'hFFFF;
        cyc();
        start = 1'b0;
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_busy[0]", 16'(busy_v[0]), 16'h0);
        chk("flush_done[0]", 16'(done_v[0]), 16'h0);
        chk("flush_result[0]", result_v[0], 16'h000A);
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            cyc();
            if (done_v[0]) seen = 1'b1;
        end
        chk("flush_no_done[0]", 16'(seen), 16'h0);

        // Flush and start together: start dropped.
        flush = 1'b1;
        start = 1'b1;
        A = 16'h7777;
        B = 16'h7777;
        cyc();
        flush = 1'b0;
        start = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++)
            chk($sformatf("flush_start_busy[%0d]", k), 16'(busy_v[k]), 16'h0);
        chk("flush_start_result[0]", result_v[0], 16'h000A);

        // Back-to-back: start held through DONE with new operands.
        start = 1'b1;
        A = 16'h1234;
        B = 16'h0000;
        cyc();
        A = 16'h8888;
        B = 16'h8888;
        first  = -1;
        second = -1;
        for (int n = 1; n <= 30; n++) begin
            if (first > 0 && n == first + 2) start = 1'b0;
            cyc();
            if (done_v[0]) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        start = 1'b0;
        chk("b2b_first_lat[0]", 16'(first), 16'd4);
        chk("b2b_gap[0]", 16'(second - first), 16'd5);
        chk("b2b_result[0]", result_v[0], 16'hFFC0);

        // Asynchronous reset mid-accumulate.
        start = 1'b1;
        A = 16'hFFFF;
        B = 16'hFFFF;
        cyc();
        start = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("arst_busy[%0d]", k), 16'(busy_v[k]), 16'h0);
            chk($sformatf("arst_done[%0d]", k), 16'(done_v[k]), 16'h0);
            chk($sformatf("arst_result[%0d]", k), result_v[k], 16'h0000);
        end
        cyc();
        cyc();
        #2 rst_n = 1'b1;
        run_op(16'h7777, 16'h7777, -1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("post_rst_lat[%0d]", k), 16'(lat[k]), 16'(ns[k]));
            chk($sformatf("post_rst_result[%0d]", k), result_v[k], 16'h0038);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            start = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            A     = 16'($urandom);
            B     = 16'($urandom);
            cyc();
        end
        start = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        for (int n = 0; n < 8; n++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
